// File: rtl/prmcu_uart_pkg.sv
// prmcu_uart_pkg: shared types and constants for the PRMCU UART path.
// The ST_PARITY encoding exists only when PRMCU_UART_RX_PARITY_EN is defined.
package prmcu_uart_pkg;

    localparam int         UART_DEFAULT_CLK_DIVIDER = 87;    // 10 MHz / 87 ~ 115 kbaud
    localparam logic [7:0] UART_CMD_TOGGLE          = 8'h54; // shared with the hardware-test logic

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef PRMCU_UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/prmcu_uart_baud_cnt.sv
// prmcu_uart_baud_cnt: bit-time counter shared by the UART receiver and transmitter.
// Counts 0..CLK_DIVIDER-1 and wraps by itself. half_tc marks the mid-bit point
// measured from a clear, full_tc marks the end of a bit period.
module prmcu_uart_baud_cnt
    import prmcu_uart_pkg::*;
#(
    parameter int CLK_DIVIDER = UART_DEFAULT_CLK_DIVIDER
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tc,
    output logic full_tc
);

    localparam int            CW      = $clog2(CLK_DIVIDER);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIVIDER / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIVIDER - 1);

    logic [CW-1:0] cnt;

    assign half_tc = (cnt == HALF_M1);
    assign full_tc = (cnt == FULL_M1);

    // Bit-time count: restart on clear or at the end of each bit period.
    always_ff @(posedge clk) begin
        if (rst || clr || full_tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/prmcu_uart_rx.sv
// prmcu_uart_rx: UART receiver with one-entry valid/ready output buffer and
// single-cycle framing / parity / overrun pulses.
// Optional parity check: define PRMCU_UART_RX_PARITY_EN.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | line idle, waiting for a low level on rx_s
// ST_START     | timing to mid start bit; high there means a false start
// ST_DATA      | sampling N_BITS data bits at their midpoints, LSB first
// ST_PARITY    | sampling the parity bit (only with the parity macro)
// ST_STOP      | sampling N_STOP_BITS stop bits; last one completes frame
// ST_WAIT_HIGH | after a framing error, wait for the line to return high
module prmcu_uart_rx
    import prmcu_uart_pkg::*;
#(
    parameter int CLK_DIVIDER = UART_DEFAULT_CLK_DIVIDER,
    parameter int N_BITS      = 8,
    parameter int N_STOP_BITS = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [N_BITS-1:0] dat_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o
);

    localparam int            IW        = $clog2(N_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(N_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(N_STOP_BITS - 1);

    if (CLK_DIVIDER < 4) begin : g_chk_div
        $error("prmcu_uart_rx: CLK_DIVIDER must be >= 4");
    end
    if (N_BITS < 5 || N_BITS > 9) begin : g_chk_bits
        $error("prmcu_uart_rx: N_BITS must be 5..9");
    end
    if (N_STOP_BITS < 1 || N_STOP_BITS > 2) begin : g_chk_stop
        $error("prmcu_uart_rx: N_STOP_BITS must be 1..2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
        $error("prmcu_uart_rx: PARITY_ODD must be 0 or 1");
    end

    logic           rx_meta;
    logic           rx_s;
    uart_rx_state_t state, state_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic [N_BITS-1:0] shreg, shreg_nxt;
    logic           stop_bad, stop_bad_nxt;
    logic           cnt_clr;
    logic           half_tc;
    logic           full_tc;
    logic           word_done;
    logic           ferr;
`ifdef PRMCU_UART_RX_PARITY_EN
    localparam logic P_ODD = (PARITY_ODD != 0);
    logic           par_bad, par_bad_nxt;
    logic           perr;
`endif

    prmcu_uart_baud_cnt #(
        .CLK_DIVIDER (CLK_DIVIDER)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .half_tc (half_tc),
        .full_tc (full_tc)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
`ifdef PRMCU_UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            shreg    <= shreg_nxt;
            stop_bad <= stop_bad_nxt;
`ifdef PRMCU_UART_RX_PARITY_EN
            par_bad  <= par_bad_nxt;
`endif
        end
    end

    // Next-state logic; frame outcome strobes are raised on the last stop sample.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        stop_bad_nxt = stop_bad;
        cnt_clr      = 1'b0;
        word_done    = 1'b0;
        ferr         = 1'b0;
`ifdef PRMCU_UART_RX_PARITY_EN
        par_bad_nxt  = par_bad;
        perr         = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_clr      = 1'b1;
                idx_nxt      = '0;
                stop_bad_nxt = 1'b0;
`ifdef PRMCU_UART_RX_PARITY_EN
                par_bad_nxt  = 1'b0;
`endif
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (half_tc) begin
                    cnt_clr = 1'b1;
                    idx_nxt = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_tc) begin
                    // Shifting in from the top leaves bit 0 in the LSB after N_BITS samples.
                    shreg_nxt = {rx_s, shreg[N_BITS-1:1]};
                    if (idx == LAST_DATA) begin
                        idx_nxt = '0;
`ifdef PRMCU_UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
`ifdef PRMCU_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tc) begin
                    par_bad_nxt = rx_s ^ (^shreg) ^ P_ODD;
                    state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tc) begin
                    if (idx == LAST_STOP) begin
                        idx_nxt = '0;
                        if (stop_bad || !rx_s) begin
                            ferr      = 1'b1;
                            state_nxt = ST_WAIT_HIGH;
`ifdef PRMCU_UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            perr      = 1'b1;
                            state_nxt = ST_IDLE;
`endif
                        end else begin
                            word_done = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        stop_bad_nxt = stop_bad | ~rx_s;
                        idx_nxt      = idx + IW'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output buffer and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_o        <= '0;
            vld_o        <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef PRMCU_UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= ferr;
            overrun_o   <= 1'b0;
`ifdef PRMCU_UART_RX_PARITY_EN
            parity_err_o <= perr;
`endif
            if (word_done) begin
                if (!vld_o || rdy_i) begin
                    dat_o <= shreg;
                    vld_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (vld_o && rdy_i) begin
                vld_o <= 1'b0;
            end
        end
    end

`ifndef PRMCU_UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

endmodule
